// File: rtl/simon_mmio_responder.sv
// simon_mmio_responder: responder on the processor data-memory bus that serves
// the Simon Game peripherals through a six-word window: a debounced button
// event FIFO, a timed LED driver and a free-running Galois LFSR.
module simon_mmio_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'd4096,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [31:0] LFSR_SEED       = 32'hACE10001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        wren,
    input  logic        rden,
    output logic [31:0] q_io,
    output logic        io_hit,
    input  logic [3:0]  buttons_raw,
    output logic [3:0]  leds,
    output logic        led_busy
);

    localparam int          PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int          DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_POP      = 3'd1,
        REG_LED_CTRL = 3'd2,
        REG_LED_TIME = 3'd3,
        REG_RAND     = 3'd4,
        REG_CLEAR    = 3'd5
    } reg_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [31:0] offset;
    reg_e        reg_sel;
    logic        wr_acc;
    logic        rd_acc;

    // Addresses below the base wrap to huge offsets, so one compare covers both ends.
    assign offset  = address - BASE_ADDR;
    assign io_hit  = (offset < 32'd6);
    assign reg_sel = reg_e'(offset[2:0]);
    assign wr_acc  = io_hit & wren;
    // A simultaneous store takes priority, so the cycle is not a load.
    assign rd_acc  = io_hit & rden & ~wren;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]             sync1_q, sync2_q;
    logic [3:0]             deb_q, deb_d;
    logic [3:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [3:0]             press;

    logic                   push_valid;
    logic                   push_multi;
    logic [1:0]             push_idx;

    logic [1:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   fifo_full, fifo_empty;
    logic                   clear_req, pop_req, do_push;

    logic [3:0]             leds_q, leds_d;
    logic                   busy_q, busy_d;
    logic [31:0]            remaining_q, remaining_d;
    logic [31:0]            led_time_q, led_time_d;

    logic [31:0]            lfsr_q, lfsr_d;

    logic [31:0]            rd_data;
    logic [31:0]            q_io_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Button debounce: a level change is accepted after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count.
    // ------------------------------------------------------------------
    // Per-button debounce counter and level, plus the press strobe on 0->1.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        press    = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                deb_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
                press[i]    = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Pick the lowest-index press; any extra simultaneous press is an overflow.
    always_comb begin
        push_idx   = 2'd0;
        push_valid = |press;
        push_multi = (press & (press - 4'd1)) != 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) push_idx = 2'(i);
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign clear_req  = wr_acc & (reg_sel == REG_CLEAR);
    assign pop_req    = rd_acc & (reg_sel == REG_POP) & ~fifo_empty;
    assign do_push    = push_valid & ~fifo_full & ~clear_req;

    // FIFO pointers, occupancy and sticky overflow; a flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_req) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, pop_req})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push_valid && (fifo_full || push_multi)) ovf_d = 1'b1;
        end
    end

    // FIFO storage; entries are only read while counted as valid.
    // NOTE: the storage array has no reset -- occupancy gates every read, and
    // leaving it unreset lets it map onto plain register-file/RAM cells.
    always_ff @(posedge clock) begin
        if (do_push) fifo_mem[wr_ptr_q] <= push_idx;
    end

    // ------------------------------------------------------------------
    // LED timer
    // ------------------------------------------------------------------
    // LED pattern, busy flag and countdown; a LED_CTRL write (re)starts the timer.
    always_comb begin
        leds_d      = leds_q;
        busy_d      = busy_q;
        remaining_d = remaining_q;
        led_time_d  = led_time_q;
        if (wr_acc && reg_sel == REG_LED_TIME) begin
            led_time_d = data_in;
        end
        if (wr_acc && reg_sel == REG_LED_CTRL) begin
            leds_d      = data_in[3:0];
            remaining_d = led_time_q;
            busy_d      = (led_time_q != '0);
        end else if (busy_q) begin
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
                busy_d = 1'b0;
                leds_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // LFSR: nonzero seed plus a primitive polynomial keeps it off zero.
    // ------------------------------------------------------------------
    assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    // ------------------------------------------------------------------
    // Read mux and falling-edge read register
    // ------------------------------------------------------------------
    // Read data for the addressed register; write-only offsets return 0.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS:   rd_data = {ovf_q, 27'b0, 4'(count_q)};
            REG_POP:      if (!fifo_empty) rd_data = {27'b0, 1'b1, 2'b00, fifo_mem[rd_ptr_q]};
            REG_LED_CTRL: rd_data = {28'b0, leds_q};
            REG_LED_TIME: rd_data = remaining_q;
            REG_RAND:     rd_data = lfsr_q;
            default:      rd_data = '0;
        endcase
    end

    // All rising-edge state; asynchronous reset aborts timers and debounces.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            db_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            leds_q      <= '0;
            busy_q      <= 1'b0;
            remaining_q <= '0;
            led_time_q  <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // which is what makes the two-flop synchronizer actually two flops.
            sync1_q     <= buttons_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            db_cnt_q    <= db_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            leds_q      <= leds_d;
            busy_q      <= busy_d;
            remaining_q <= remaining_d;
            led_time_q  <= led_time_d;
            lfsr_q      <= lfsr_d;
        end
    end

    // Load data captured mid-cycle so it is stable for the MW latch at the next rising edge.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            q_io_q <= '0;
        end else if (rd_acc) begin
            q_io_q <= rd_data;
        end
    end

    assign q_io     = q_io_q;
    assign leds     = leds_q;
    assign led_busy = busy_q;

endmodule

// File: tb/tb_simon_mmio_responder.sv
// Testbench for simon_mmio_responder: scenario tasks drive the bus and buttons;
// load results are queued as they are issued and compared when q_io updates.
module tb_simon_mmio_responder;

    localparam logic [31:0] BASE = 32'd4096;
    localparam logic [31:0] SEED = 32'hACE10001;
    localparam logic [31:0] A_STATUS   = BASE + 32'd0;
    localparam logic [31:0] A_POP      = BASE + 32'd1;
    localparam logic [31:0] A_LED_CTRL = BASE + 32'd2;
    localparam logic [31:0] A_LED_TIME = BASE + 32'd3;
    localparam logic [31:0] A_RAND     = BASE + 32'd4;
    localparam logic [31:0] A_CLEAR    = BASE + 32'd5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [31:0] q_io;
    logic        io_hit;
    logic [3:0]  buttons_raw = '0;
    logic [3:0]  leds;
    logic        led_busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    bit          rd_issued = 1'b0;

    simon_mmio_responder #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4),
        .LFSR_SEED      (SEED)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .data_in    (data_in),
        .wren       (wren),
        .rden       (rden),
        .q_io       (q_io),
        .io_hit     (io_hit),
        .buttons_raw(buttons_raw),
        .leds       (leds),
        .led_busy   (led_busy)
    );

    always #5 clock = ~clock;

    // Scoreboard: a load issued this cycle is captured on the falling edge.
    always @(negedge clock) begin
        if (rd_issued) begin
            logic [31:0] exp;
            string       nm;
            #1;
            rd_issued = 1'b0;
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            n_vec++;
            if (q_io !== exp) begin
                n_err++;
                $display("FAIL %s: q_io=%h expected %h", nm, q_io, exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h80200003 : 32'h0);
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        address = addr;
        rden    = 1'b1;
        wren    = 1'b0;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        rd_issued = 1'b1;
        @(posedge clock);
        #1;
        rden    = 1'b0;
        address = '0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        address = addr;
        data_in = data;
        wren    = 1'b1;
        rden    = 1'b0;
        @(posedge clock);
        #1;
        wren    = 1'b0;
        address = '0;
        data_in = '0;
    endtask

    task automatic do_reset();
        buttons_raw = '0;
        rden        = 1'b0;
        wren        = 1'b0;
        address     = '0;
        reset       = 1'b0;
        idle(2);
        reset       = 1'b1;
    endtask

    task automatic press_buttons(input logic [3:0] mask);
        buttons_raw = mask;
        idle(10);
        buttons_raw = '0;
        idle(10);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        address = A_RAND;
        #3;
        n_vec++;
        if (leds !== 4'b0 || led_busy !== 1'b0 || q_io !== 32'h0 || io_hit !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: leds=%b busy=%b q_io=%h io_hit=%b expected 0000 0 0 1",
                     leds, led_busy, q_io, io_hit);
        end
        idle(2);
        reset = 1'b1;
        bus_read(A_RAND, SEED, "reset_rand_seed");
        bus_read(A_STATUS, 32'h0, "reset_status");
        bus_read(A_LED_TIME, 32'h0, "reset_remaining");
    endtask

    task automatic test_debounce();
        do_reset();
        buttons_raw = 4'b0100;
        idle(2);
        buttons_raw = 4'b0000;
        idle(8);
        bus_read(A_STATUS, 32'h0, "glitch_status");
        buttons_raw = 4'b0100;
        idle(10);
        buttons_raw = 4'b0000;
        idle(10);
        bus_read(A_STATUS, 32'h1, "debounce_status");
        bus_read(A_POP, 32'h12, "debounce_pop");
        bus_read(A_STATUS, 32'h0, "debounce_status_after_pop");
    endtask

    task automatic test_fifo_overflow();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++) press_buttons(seq[i]);
        bus_read(A_STATUS, 32'h80000004, "ovf_status");
        for (int i = 0; i < 4; i++) bus_read(A_POP, 32'h10 + 32'(i), $sformatf("ovf_pop%0d", i));
        bus_read(A_POP, 32'h0, "ovf_pop_empty");
        bus_read(A_STATUS, 32'h80000000, "ovf_status_drained");
        bus_write(A_CLEAR, 32'hFFFFFFFF);
        bus_read(A_STATUS, 32'h0, "ovf_status_cleared");
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_buttons(4'b1010);
        bus_read(A_STATUS, 32'h80000001, "simul_status");
        bus_read(A_POP, 32'h11, "simul_pop");
        bus_write(A_CLEAR, 32'h0);
        // Push on the same edge as a pop of a one-entry FIFO.
        press_buttons(4'b0001);
        buttons_raw = 4'b1000;
        idle(5);
        bus_read(A_POP, 32'h10, "pushpop_pop_old");
        buttons_raw = 4'b0000;
        bus_read(A_STATUS, 32'h1, "pushpop_status");
        bus_read(A_POP, 32'h13, "pushpop_pop_new");
        idle(8);
        // Push on the same edge as a read of an empty FIFO.
        buttons_raw = 4'b0100;
        idle(5);
        bus_read(A_POP, 32'h0, "empty_pushpop_pop");
        buttons_raw = 4'b0000;
        bus_read(A_STATUS, 32'h1, "empty_pushpop_status");
        bus_read(A_POP, 32'h12, "empty_pushpop_pop_new");
        idle(8);
    endtask

    task automatic test_led_timer();
        do_reset();
        bus_write(A_LED_TIME, 32'd3);
        bus_write(A_LED_CTRL, 32'hA);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (leds !== 4'b1010 || led_busy !== 1'b1) begin
                n_err++;
                $display("FAIL led_on%0d: leds=%b busy=%b expected 1010 1", i, leds, led_busy);
            end
            idle(1);
        end
        n_vec++;
        if (leds !== 4'b0000 || led_busy !== 1'b0) begin
            n_err++;
            $display("FAIL led_expire: leds=%b busy=%b expected 0000 0", leds, led_busy);
        end
        // Restart mid-count with a new pattern.
        bus_write(A_LED_CTRL, 32'hA);
        idle(1);
        bus_write(A_LED_CTRL, 32'h1);
        bus_read(A_LED_TIME, 32'd3, "led_restart_remaining");
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (leds !== 4'b0001 || led_busy !== 1'b1) begin
                n_err++;
                $display("FAIL led_restart%0d: leds=%b busy=%b expected 0001 1", i, leds, led_busy);
            end
            idle(1);
        end
        n_vec++;
        if (leds !== 4'b0000 || led_busy !== 1'b0) begin
            n_err++;
            $display("FAIL led_restart_expire: leds=%b busy=%b expected 0000 0", leds, led_busy);
        end
        // Zero duration holds the pattern indefinitely.
        bus_write(A_LED_TIME, 32'd0);
        bus_write(A_LED_CTRL, 32'h6);
        idle(8);
        n_vec++;
        if (leds !== 4'b0110 || led_busy !== 1'b0) begin
            n_err++;
            $display("FAIL led_hold: leds=%b busy=%b expected 0110 0", leds, led_busy);
        end
        bus_read(A_LED_CTRL, 32'h6, "led_ctrl_readback");
        bus_read(A_LED_TIME, 32'h0, "led_hold_remaining");
    endtask

    task automatic test_decode();
        logic [31:0] probe [4] = '{BASE - 32'd1, BASE, BASE + 32'd5, BASE + 32'd6};
        logic        hit   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            address = probe[i];
            #1;
            n_vec++;
            if (io_hit !== hit[i]) begin
                n_err++;
                $display("FAIL io_hit_%h: io_hit=%b expected %b", probe[i], io_hit, hit[i]);
            end
        end
        address = '0;
        // Out-of-window stores must not reach LED_TIME or LED_CTRL.
        bus_write(BASE + 32'd6, 32'h7);
        bus_write(BASE - 32'd1, 32'h7);
        bus_write(BASE - 32'd2, 32'h7);
        bus_write(BASE + 32'd7, 32'h7);
        n_vec++;
        if (leds !== 4'b0000 || led_busy !== 1'b0) begin
            n_err++;
            $display("FAIL decode_no_effect: leds=%b busy=%b expected 0000 0", leds, led_busy);
        end
        bus_read(A_LED_CTRL, 32'h0, "decode_led_ctrl");
        bus_read(A_CLEAR, 32'h0, "decode_read_write_only");
        bus_write(A_LED_CTRL, 32'h5);
        bus_read(A_LED_CTRL, 32'h5, "decode_led_ctrl_set");
        idle(3);
        n_vec++;
        if (q_io !== 32'h5) begin
            n_err++;
            $display("FAIL q_io_hold: q_io=%h expected %h", q_io, 32'h5);
        end
        // Load and store together at POP: the store wins and nothing is popped.
        press_buttons(4'b0010);
        address = A_POP;
        rden    = 1'b1;
        wren    = 1'b1;
        idle(1);
        rden    = 1'b0;
        wren    = 1'b0;
        address = '0;
        bus_read(A_STATUS, 32'h1, "rdwr_no_pop_status");
        bus_read(A_POP, 32'h11, "rdwr_no_pop_entry");
    endtask

    task automatic test_lfsr();
        logic [31:0] v;
        do_reset();
        v = SEED;
        bus_read(A_RAND, v, "lfsr_first");
        v = lfsr_step(v);
        bus_read(A_RAND, v, "lfsr_next");
        for (int i = 0; i < 5; i++) v = lfsr_step(v);
        idle(4);
        bus_read(A_RAND, v, "lfsr_after_idle");
    endtask

    task automatic test_async_reset();
        do_reset();
        press_buttons(4'b0001);
        press_buttons(4'b0100);
        bus_write(A_LED_TIME, 32'd20);
        bus_write(A_LED_CTRL, 32'hF);
        bus_read(A_STATUS, 32'h2, "pre_reset_status");
        idle(2);
        n_vec++;
        if (leds !== 4'b1111 || led_busy !== 1'b1 || q_io !== 32'h2) begin
            n_err++;
            $display("FAIL pre_reset_state: leds=%b busy=%b q_io=%h expected 1111 1 2",
                     leds, led_busy, q_io);
        end
        #2;
        reset   = 1'b0;
        address = A_RAND;
        #1;
        n_vec++;
        if (leds !== 4'b0000 || led_busy !== 1'b0 || q_io !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: leds=%b busy=%b q_io=%h expected 0000 0 0",
                     leds, led_busy, q_io);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus_read(A_RAND, SEED, "post_reset_rand");
        bus_read(A_STATUS, 32'h0, "post_reset_status");
        bus_read(A_LED_TIME, 32'h0, "post_reset_remaining");
        n_vec++;
        if (leds !== 4'b0000 || led_busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_leds: leds=%b busy=%b expected 0000 0", leds, led_busy);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_fifo_overflow();
        test_simultaneous();
        test_led_timer();
        test_decode();
        test_lfsr();
        test_async_reset();
        idle(2);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d loads never compared, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
